dec_ex_pipeline_reg: RTL and testbench
======================================

# dec_ex_pipeline_reg

Decode-to-execute pipeline register for the 5-stage RV32I core. It captures decoded control and operand data at each clock edge and drives the execute stage. Its `ex_rs1_addr`, `ex_rs2_addr` and `ex_rd_addr` outputs feed the forwarding logic. It also detects load-use hazards, which forwarding cannot resolve: it inserts a one-cycle bubble and stalls fetch/decode. It honours the branch flush and an external hold.

## Interface
- `XLEN`, 32, data/PC width
- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-high reset
- `hold` input 1: freeze register (downstream memory stall)
- `flush` input 1: branch taken in EX; squash the incoming instruction (driven from `flush_dec_ex_pipeline`)
- `dec_valid` input 1: decode slot holds a real instruction
- `dec_pc`, `dec_rs1_data`, `dec_rs2_data`, `dec_imm` input XLEN each: decoded values
- `dec_rs1_addr`, `dec_rs2_addr`, `dec_rd_addr` input 5 each: register indices
- `dec_uses_rs1`, `dec_uses_rs2` input 1 each: instruction reads that source
- `dec_ctrl` input `ex_ctrl_t`: alu_op[3:0], alu_src_b, reg_write, mem_read, mem_write, wb_sel[1:0], branch, jump
- `ex_valid` output 1, plus `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_rs1_addr`, `ex_rs2_addr`, `ex_rd_addr`, `ex_ctrl`: registered copies of the corresponding `dec_*` inputs
- `stall_if_dec` output 1: combinational; hold PC and the IF/DEC register this cycle
- `bubble_count` output 32: number of load-use bubbles inserted; wraps at 2^32

## Operation
- **Reset:** all outputs and register fields go to 0. The reset register is a bubble.
- **load_use:** asserted when all of the following are true:
  - `ex_valid`, `ex_ctrl.mem_read`, and `ex_rd_addr != 0`
  - `dec_valid`
  - at least one source matches: (`dec_uses_rs1` and `dec_rs1_addr == ex_rd_addr`) or (`dec_uses_rs2` and `dec_rs2_addr == ex_rd_addr`)
  - `!flush`
- **Stall output:** `stall_if_dec = (load_use | hold) & !rst`.
- **Per-edge priority** (first match wins):
  1. `rst`: clear the register.
  2. `hold`: keep every field unchanged.
  3. `flush`: load a bubble.
  4. `load_use`: load a bubble and increment `bubble_count`.
  5. Otherwise: load all `dec_*` fields; `ex_valid <= dec_valid`.
- **Bubble contents:** every field is zero. This includes the register addresses, so the forwarding logic never matches a bubble (x0 is excluded there).
- **Invalid inputs:** if `dec_valid = 0`, the fields are still loaded but the register behaves as a bubble. Its `ctrl` bits are gated to zero on load.
- **bubble_count:** increments only in case 4. It saturates nowhere; 0xFFFF_FFFF + 1 wraps to 0.

## Timing
- Latency: one cycle from `dec_*` inputs to `ex_*` outputs.
- `stall_if_dec` is combinational from the current `ex_*` state and the `dec_*` inputs, in the same cycle. Upstream samples it at the same edge.
- A load-use hazard costs exactly one bubble. On the following cycle the load is in MEM, the stalled instruction is re-presented, `load_use` is 0 and the instruction loads normally. Forwarding then supplies the data from the WB path.
- **`flush` and `load_use` in the same cycle:** `flush` wins. `load_use` is gated off, the counter does not increment and there is no stall.
- **`hold` and `flush` in the same cycle:** `hold` wins and the flush is deferred. `flush` is still asserted the cycle after hold deasserts, because the branch remains in EX.
- **`rst` mid-stall:** the register clears and `stall_if_dec` is 0 in the reset cycle.

## Structure
- Shared package `core_pkg` holds:
  - `ex_ctrl_t` (packed struct)
  - `alu_op_t` and `wb_sel_t` enums
  - `EX_CTRL_NOP` constant (all zeros)
- Separate sub-module `load_use_detector`, purely combinational: its inputs are the EX load and the decode sources; its output is `load_use`.
- The register and counter live in `dec_ex_pipeline_reg`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random `dec_*` inputs. Required response: all `ex_*` = 0, `bubble_count` = 0, `stall_if_dec` = 0.
- **Load-use:**
  - Stimulus: `lw x5` enters EX; decode presents `add x6,x5,x1` (`dec_uses_rs1`, rs1 = 5).
  - Required response: `stall_if_dec` = 1 for one cycle; the next EX is a bubble (`ex_valid` = 0, `ex_rd_addr` = 0); `bubble_count` = 1.
  - On the following cycle the `add` appears in EX with `ex_rs1_addr` = 5.
- **x0 and unused-source exemptions:**
  - `lw x0` followed by `add x1,x0,x0`: no stall.
  - `lw x5` followed by `lui x5` (no rs used): no stall.
- **flush priority:**
  - Stimulus: `flush` = 1 while a load-use condition is also true.
  - Required response: EX becomes a bubble, `stall_if_dec` = 0, `bubble_count` unchanged.
- **hold priority:**
  - Stimulus: `hold` = 1 for 3 cycles together with `flush` = 1.
  - Required response: the `ex_*` fields are unchanged across the 3 cycles; the bubble loads on the first cycle after `hold` drops.
- **Counter wrap:**
  - Stimulus: force `bubble_count` to 0xFFFF_FFFF and trigger one load-use.
  - Required response: `bubble_count` = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the RV32I core: execute-stage control bundle and its encodings.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  // ALU operation selector carried into EX
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  // Write-back source selector
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  // Control bits consumed by EX/MEM/WB
  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_b;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    wb_sel_t wb_sel;
    logic    branch;
    logic    jump;
  } ex_ctrl_t;

  // All-zero control word: no register write, no memory access
  localparam ex_ctrl_t EX_CTRL_NOP = ex_ctrl_t'('0);

endpackage

// File: rtl/load_use_detector.sv
// Flags a decode-stage instruction that reads the destination of a load sitting in EX.
// Forwarding cannot cover this case, so the pipeline must insert one bubble.
module load_use_detector
  import core_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  logic                  flush,
  output logic                  load_use
);

  logic ex_is_load;
  logic src_match;

  // A load to x0 produces nothing to wait for; a flushed decode slot is discarded anyway
  always_comb begin
    ex_is_load = ex_valid & ex_mem_read & (ex_rd_addr != '0);
    src_match  = (dec_uses_rs1 & (dec_rs1_addr == ex_rd_addr)) |
                 (dec_uses_rs2 & (dec_rs2_addr == ex_rd_addr));
    load_use   = ex_is_load & dec_valid & src_match & ~flush;
  end

endmodule

// File: rtl/dec_ex_pipeline_reg.sv
// DEC/EX pipeline register with load-use bubble insertion, flush and hold.
// Bubbles are all-zero, including register indices, so forwarding never matches them.
module dec_ex_pipeline_reg
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  dec_valid,
  input  logic [XLEN-1:0]       dec_pc,
  input  logic [XLEN-1:0]       dec_rs1_data,
  input  logic [XLEN-1:0]       dec_rs2_data,
  input  logic [XLEN-1:0]       dec_imm,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  ex_ctrl_t              dec_ctrl,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output ex_ctrl_t              ex_ctrl,
  output logic                  stall_if_dec,
  output logic [31:0]           bubble_count
);

  logic                  valid_reg;
  logic [XLEN-1:0]       pc_reg;
  logic [XLEN-1:0]       rs1_data_reg;
  logic [XLEN-1:0]       rs2_data_reg;
  logic [XLEN-1:0]       imm_reg;
  logic [REG_ADDR_W-1:0] rs1_addr_reg;
  logic [REG_ADDR_W-1:0] rs2_addr_reg;
  logic [REG_ADDR_W-1:0] rd_addr_reg;
  ex_ctrl_t              ctrl_reg;
  logic [31:0]           bubble_count_reg;
  logic                  load_use;

  load_use_detector u_load_use_detector (
    .ex_valid     (valid_reg),
    .ex_mem_read  (ctrl_reg.mem_read),
    .ex_rd_addr   (rd_addr_reg),
    .dec_valid    (dec_valid),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_uses_rs1 (dec_uses_rs1),
    .dec_uses_rs2 (dec_uses_rs2),
    .flush        (flush),
    .load_use     (load_use)
  );

  // Upstream freezes on a hazard or downstream hold; never while reset is asserted
  assign stall_if_dec = (load_use | hold) & ~rst;

  // Pipeline register: reset > hold > flush > load-use bubble > normal load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg        <= 1'b0;
      pc_reg           <= '0;
      rs1_data_reg     <= '0;
      rs2_data_reg     <= '0;
      imm_reg          <= '0;
      rs1_addr_reg     <= '0;
      rs2_addr_reg     <= '0;
      rd_addr_reg      <= '0;
      ctrl_reg         <= EX_CTRL_NOP;
      bubble_count_reg <= '0;
    end else if (hold) begin
      // every field keeps its value; a pending flush waits for hold to drop
    end else if (flush || load_use) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      rs1_addr_reg <= '0;
      rs2_addr_reg <= '0;
      rd_addr_reg  <= '0;
      ctrl_reg     <= EX_CTRL_NOP;
      // the detector already masks load_use under flush; the explicit test keeps the priority obvious
      if (!flush) begin
        bubble_count_reg <= bubble_count_reg + 32'd1;
      end
    end else begin
      valid_reg    <= dec_valid;
      pc_reg       <= dec_pc;
      rs1_data_reg <= dec_rs1_data;
      rs2_data_reg <= dec_rs2_data;
      imm_reg      <= dec_imm;
      rs1_addr_reg <= dec_rs1_addr;
      rs2_addr_reg <= dec_rs2_addr;
      rd_addr_reg  <= dec_rd_addr;
      // an empty slot must not carry live control into EX
      ctrl_reg     <= dec_valid ? dec_ctrl : EX_CTRL_NOP;
    end
  end

  assign ex_valid     = valid_reg;
  assign ex_pc        = pc_reg;
  assign ex_rs1_data  = rs1_data_reg;
  assign ex_rs2_data  = rs2_data_reg;
  assign ex_imm       = imm_reg;
  assign ex_rs1_addr  = rs1_addr_reg;
  assign ex_rs2_addr  = rs2_addr_reg;
  assign ex_rd_addr   = rd_addr_reg;
  assign ex_ctrl      = ctrl_reg;
  assign bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_dec_ex_pipeline_reg.sv
// Directed bench for the DEC/EX register: reset, load-use, exemptions, flush/hold priority, counter wrap.
module tb_dec_ex_pipeline_reg;
  import core_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, hold, flush, dec_valid;
  logic [XLEN-1:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
  logic [4:0]      dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic            dec_uses_rs1, dec_uses_rs2;
  ex_ctrl_t        dec_ctrl;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  ex_ctrl_t        ex_ctrl;
  logic            stall_if_dec;
  logic [31:0]     bubble_count;

  int errors = 0;
  int checks = 0;

  ex_ctrl_t c_lw, c_add, c_sw;

  always #5 clk = ~clk;

  dec_ex_pipeline_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_rs1_data(dec_rs1_data),
    .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_ctrl(dec_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl), .stall_if_dec(stall_if_dec),
    .bubble_count(bubble_count)
  );

  // Single comparison point: counts, prints one line per check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one decode slot; data/imm are derived from pc so they are distinguishable
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input ex_ctrl_t c);
    dec_valid    = v;
    dec_pc       = pc;
    dec_rs1_data = pc ^ 32'hA5A5_0000;
    dec_rs2_data = pc ^ 32'h5A5A_0000;
    dec_imm      = pc + 32'd1;
    dec_rs1_addr = rs1;
    dec_rs2_addr = rs2;
    dec_rd_addr  = rd;
    dec_uses_rs1 = u1;
    dec_uses_rs2 = u2;
    dec_ctrl     = c;
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_rd"},    64'(ex_rd_addr), 64'd0);
    check({tag, "_pc"},    64'(ex_pc), 64'd0);
    check({tag, "_ctrl"},  64'(ex_ctrl), 64'd0);
  endtask

  initial begin
    c_lw  = EX_CTRL_NOP; c_lw.alu_src_b = 1'b1; c_lw.reg_write = 1'b1;
    c_lw.mem_read = 1'b1; c_lw.wb_sel = WB_MEM;
    c_add = EX_CTRL_NOP; c_add.reg_write = 1'b1;
    c_sw  = EX_CTRL_NOP; c_sw.alu_src_b = 1'b1; c_sw.mem_write = 1'b1;

    // Reset with random decode inputs, hold asserted in the second cycle
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, ex_ctrl_t'(12'($urandom)));
    tick();
    hold = 1'b1;
    drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, c_lw);
    check("rst_stall_with_hold", 64'(stall_if_dec), 64'd0);
    tick();
    check_bubble("rst");
    check("rst_rs1_data", 64'(ex_rs1_data), 64'd0);
    check("rst_imm", 64'(ex_imm), 64'd0);
    check("rst_count", 64'(bubble_count), 64'd0);
    check("rst_stall", 64'(stall_if_dec), 64'd0);

    // lw x5 enters EX
    rst = 1'b0; hold = 1'b0;
    drive(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, c_lw);
    check("lw_stall", 64'(stall_if_dec), 64'd0);
    tick();
    check("lw_valid", 64'(ex_valid), 64'd1);
    check("lw_rd", 64'(ex_rd_addr), 64'd5);
    check("lw_ctrl", 64'(ex_ctrl), 64'h0E4);

    // add x6,x5,x1 -> one bubble
    drive(1'b1, 32'h104, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, c_add);
    check("lu_stall", 64'(stall_if_dec), 64'd1);
    tick();
    check_bubble("lu_bubble");
    check("lu_count", 64'(bubble_count), 64'd1);
    check("lu_stall_after", 64'(stall_if_dec), 64'd0);
    tick();
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_rs1", 64'(ex_rs1_addr), 64'd5);
    check("add_rs2", 64'(ex_rs2_addr), 64'd1);
    check("add_rd", 64'(ex_rd_addr), 64'd6);
    check("add_pc", 64'(ex_pc), 64'h104);
    check("add_rs1_data", 64'(ex_rs1_data), 64'hA5A5_0104);
    check("add_rs2_data", 64'(ex_rs2_data), 64'h5A5A_0104);
    check("add_imm", 64'(ex_imm), 64'h105);
    check("add_ctrl", 64'(ex_ctrl), 64'h040);

    // lw x0 then add x1,x0,x0: no stall
    drive(1'b1, 32'h108, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, c_lw);
    tick();
    drive(1'b1, 32'h10C, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, c_add);
    check("x0_stall", 64'(stall_if_dec), 64'd0);
    tick();
    check("x0_valid", 64'(ex_valid), 64'd1);
    check("x0_rd", 64'(ex_rd_addr), 64'd1);

    // lw x5 then lui x5 (index fields equal 5, but unused): no stall
    drive(1'b1, 32'h110, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, c_lw);
    tick();
    drive(1'b1, 32'h114, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, c_add);
    check("lui_stall", 64'(stall_if_dec), 64'd0);
    tick();
    check("lui_valid", 64'(ex_valid), 64'd1);
    check("lui_pc", 64'(ex_pc), 64'h114);
    check("lui_count", 64'(bubble_count), 64'd1);

    // lw x7 then store using x7 as rs2 -> stall via the rs2 path
    drive(1'b1, 32'h118, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, c_lw);
    tick();
    drive(1'b1, 32'h11C, 5'd3, 5'd7, 5'd0, 1'b1, 1'b1, c_sw);
    check("rs2_stall", 64'(stall_if_dec), 64'd1);
    tick();
    check("rs2_valid", 64'(ex_valid), 64'd0);
    check("rs2_count", 64'(bubble_count), 64'd2);

    // flush together with a load-use condition: flush wins, no count
    drive(1'b1, 32'h120, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, c_lw);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h124, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, c_add);
    check("flush_stall", 64'(stall_if_dec), 64'd0);
    tick();
    flush = 1'b0;
    check_bubble("flush");
    check("flush_count", 64'(bubble_count), 64'd2);

    // hold with flush for 3 cycles: EX frozen, bubble after hold drops
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, c_add);
    tick();
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, c_lw);
      check($sformatf("hold%0d_stall", i), 64'(stall_if_dec), 64'd1);
      tick();
      check($sformatf("hold%0d_pc", i), 64'(ex_pc), 64'h200);
      check($sformatf("hold%0d_rd", i), 64'(ex_rd_addr), 64'd9);
      check($sformatf("hold%0d_valid", i), 64'(ex_valid), 64'd1);
    end
    hold = 1'b0;
    drive(1'b1, 32'h304, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, c_lw);
    check("unhold_stall", 64'(stall_if_dec), 64'd0);
    tick();
    flush = 1'b0;
    check_bubble("unhold");

    // invalid slot: data fields load, control is gated to zero
    drive(1'b0, 32'h400, 5'd8, 5'd9, 5'd4, 1'b1, 1'b1, c_add);
    tick();
    check("inv_valid", 64'(ex_valid), 64'd0);
    check("inv_pc", 64'(ex_pc), 64'h400);
    check("inv_ctrl", 64'(ex_ctrl), 64'd0);

    // counter wrap: preset to all ones, then one load-use
    dut.bubble_count_reg = 32'hFFFF_FFFF;
    drive(1'b1, 32'h500, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, c_lw);
    tick();
    check("wrap_pre", 64'(bubble_count), 64'hFFFF_FFFF);
    drive(1'b1, 32'h504, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, c_add);
    check("wrap_stall", 64'(stall_if_dec), 64'd1);
    tick();
    check("wrap_count", 64'(bubble_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
